// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg
// Shared definitions for the Wishbone round-robin arbiter and its
// round-robin picker: bus field widths, the arbiter state encoding and
// small index helpers.
package wb_arbiter_pkg;

  localparam int WB_ADR_W = 36;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  localparam int MAX_NM   = 4;
  localparam int PTR_W    = $clog2(MAX_NM);

  // One-hot state encoding
  localparam logic [2:0] IDLE  = 3'b001;
  localparam logic [2:0] OWNED = 3'b010;
  localparam logic [2:0] ABORT = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE  = IDLE,
    ST_OWNED = OWNED,
    ST_ABORT = ABORT
  } state_e;

  // Distance of index idx from base when counting upward modulo nm.
  function automatic int rr_dist(input int idx, input int base, input int nm);
    return (idx - base + nm) % nm;
  endfunction

  // Binary index of the set bit of a one-hot vector (0 when empty).
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [MAX_NM-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NM; i++) begin
      if (oh[i]) begin
        idx = PTR_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin priority encoder. Grants the first set bit of
// req found searching upward from index ptr, wrapping modulo NM.
// Ports:
//   req [NM]    : request vector
//   ptr [PTR_W] : starting index of the search (must be < NM)
//   gnt [NM]    : one-hot grant, all zero when no request
module rr_pick
  import wb_arbiter_pkg::*;
#(
  parameter int NM = 3
) (
  input  logic [NM-1:0]    req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NM-1:0]    gnt
);

  int best_d;
  int dist_d;

  // Keep the requester with the smallest upward distance from ptr.
  always_comb begin
    gnt    = '0;
    best_d = NM;
    dist_d = 0;
    for (int i = 0; i < NM; i++) begin
      dist_d = rr_dist(i, int'(ptr), NM);
      if (req[i] && (dist_d < best_d)) begin
        best_d = dist_d;
        gnt    = '0;
        gnt[i] = 1'b1;
      end else begin
        best_d = best_d;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter
// Round-robin Wishbone arbiter sharing one slave port between NM masters.
// A grant is held for the whole cyc of the owning master so block
// transfers stay atomic. Responses and read data pass combinationally.
// Optional feature macro: WB_ARBITER_WATCHDOG_EN adds a stall counter that
// aborts a cycle with an err pulse after TIMEOUT stalled clocks.
// Ports:
//   clk, nrst                 : clock, async active-low reset
//   m_cyc_i/m_stb_i/m_we_i    : per-master control [NM]
//   m_sel_i/m_adr_i/m_dat_i   : per-master packed selects/address/write data
//   m_dat_o                   : read data broadcast to all masters
//   m_ack_o/m_err_o           : per-master responses [NM]
//   s_*_o                     : slave-side request
//   s_dat_i/s_ack_i/s_err_i   : slave responses
//   gnt_o                     : one-hot current grant
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NM      = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [NM-1:0]          m_cyc_i,
  input  logic [NM-1:0]          m_stb_i,
  input  logic [NM-1:0]          m_we_i,
  input  logic [WB_SEL_W*NM-1:0] m_sel_i,
  input  logic [WB_ADR_W*NM-1:0] m_adr_i,
  input  logic [WB_DAT_W*NM-1:0] m_dat_i,
  output logic [WB_DAT_W-1:0]    m_dat_o,
  output logic [NM-1:0]          m_ack_o,
  output logic [NM-1:0]          m_err_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [WB_SEL_W-1:0]    s_sel_o,
  output logic [WB_ADR_W-1:0]    s_adr_o,
  output logic [WB_DAT_W-1:0]    s_dat_o,
  input  logic [WB_DAT_W-1:0]    s_dat_i,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  output logic [NM-1:0]          gnt_o
);

  state_e           state_q, state_d;
  logic [NM-1:0]    gnt_q, gnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [NM-1:0]    pick_s;
  logic [PTR_W-1:0] gnt_idx_s;
  logic [PTR_W-1:0] ptr_inc_s;
  logic             owned_s;
  logic             own_cyc_s;
  logic             abort_s;

  rr_pick #(
    .NM (NM)
  ) u_pick (
    .req (m_cyc_i),
    .ptr (ptr_q),
    .gnt (pick_s)
  );

  assign owned_s   = (state_q == ST_OWNED);
  assign own_cyc_s = |(m_cyc_i & gnt_q);
  assign gnt_idx_s = onehot_to_idx(MAX_NM'(gnt_q));
  assign ptr_inc_s = (gnt_idx_s == PTR_W'(NM - 1)) ? '0 : (gnt_idx_s + PTR_W'(1));

`ifdef WB_ARBITER_WATCHDOG_EN
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        wd_stall_s;
  logic        wd_expire_s;

  // A clock counts as stalled only while a strobe is outstanding unanswered.
  assign wd_stall_s  = owned_s & s_stb_o & ~s_ack_i & ~s_err_i;
  assign wd_expire_s = wd_stall_s & (wd_cnt_q == (TIMEOUT_C - 16'd1));
  assign abort_s     = (state_q == ST_ABORT);

  // Stall counter next value: count stalled clocks, clear otherwise.
  always_comb begin
    if (wd_stall_s) begin
      wd_cnt_d = wd_cnt_q + 16'd1;
    end else begin
      wd_cnt_d = 16'd0;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wd_cnt_q <= 16'd0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^(16'(TIMEOUT));
  assign abort_s          = 1'b0;
`endif

  // Next-state logic: arbitrate in IDLE, hold grant until cyc drops.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          gnt_d   = pick_s;
          state_d = ST_OWNED;
        end else begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_OWNED: begin
        if (!own_cyc_s) begin
          gnt_d   = '0;
          ptr_d   = ptr_inc_s;
          state_d = ST_IDLE;
        end
`ifdef WB_ARBITER_WATCHDOG_EN
        else if (wd_expire_s) begin
          state_d = ST_ABORT;
        end
`endif
        else begin
          state_d = ST_OWNED;
        end
      end
`ifdef WB_ARBITER_WATCHDOG_EN
      ST_ABORT: begin
        gnt_d   = '0;
        ptr_d   = ptr_inc_s;
        state_d = ST_IDLE;
      end
`endif
      default: begin
        gnt_d   = '0;
        ptr_d   = ptr_q;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant and pointer registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Slave-side data mux: each master's fields are masked by its grant bit,
  // so non-granted masters can never leak onto the bus.
  always_comb begin
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    for (int i = 0; i < NM; i++) begin
      s_we_o  = s_we_o  | (m_we_i[i] & gnt_q[i]);
      s_sel_o = s_sel_o | (m_sel_i[WB_SEL_W*i +: WB_SEL_W] & {WB_SEL_W{gnt_q[i]}});
      s_adr_o = s_adr_o | (m_adr_i[WB_ADR_W*i +: WB_ADR_W] & {WB_ADR_W{gnt_q[i]}});
      s_dat_o = s_dat_o | (m_dat_i[WB_DAT_W*i +: WB_DAT_W] & {WB_DAT_W{gnt_q[i]}});
    end
  end

  // cyc follows the owner's cyc directly so it drops in the release clock;
  // stb is qualified by cyc so it can never appear alone.
  assign s_cyc_o = owned_s & own_cyc_s;
  assign s_stb_o = owned_s & (|(m_stb_i & m_cyc_i & gnt_q));

  assign m_dat_o = s_dat_i & {WB_DAT_W{owned_s}};
  assign m_ack_o = gnt_q & {NM{owned_s & s_ack_i}};
  assign m_err_o = gnt_q & {NM{(owned_s & s_err_i) | abort_s}};
  assign gnt_o   = gnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter
// Directed self-checking bench for wb_arbiter with three masters.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. The watchdog scenario is built when WB_ARBITER_WATCHDOG_EN
// is defined (TIMEOUT = 8).
module tb_wb_arbiter;

  logic         clk;
  logic         nrst;
  logic [2:0]   m_cyc, m_stb, m_we;
  logic [11:0]  m_sel;
  logic [107:0] m_adr;
  logic [95:0]  m_dat;
  logic [31:0]  m_dat_o;
  logic [2:0]   m_ack_o, m_err_o, gnt_o;
  logic         s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]   s_sel_o;
  logic [35:0]  s_adr_o;
  logic [31:0]  s_dat_o, s_dat_i;
  logic         s_ack_i, s_err_i;

  int errors = 0;
  int checks = 0;

  wb_arbiter #(
    .NM      (3),
    .TIMEOUT (8)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_we_i  (m_we),
    .m_sel_i (m_sel),
    .m_adr_i (m_adr),
    .m_dat_i (m_dat),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_sel_o (s_sel_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .s_err_i (s_err_i),
    .gnt_o   (gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_master(input int i, input logic cyc, input logic we,
                            input logic [35:0] adr, input logic [31:0] dat);
    m_cyc[i]          = cyc;
    m_stb[i]          = cyc;
    m_we[i]           = we;
    m_sel[4*i +: 4]   = cyc ? 4'hF : 4'h0;
    m_adr[36*i +: 36] = adr;
    m_dat[32*i +: 32] = dat;
  endtask

  task automatic clear_inputs();
    m_cyc = 3'b000; m_stb = 3'b000; m_we = 3'b000;
    m_sel = 12'h0; m_adr = 108'h0; m_dat = 96'h0;
    s_dat_i = 32'h0; s_ack_i = 1'b0; s_err_i = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    clear_inputs();
    drive_edge();
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    m_cyc = 3'b111; m_stb = 3'b111; s_ack_i = 1'b1; s_err_i = 1'b1;
    sample();
    checks++; if (gnt_o !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", gnt_o); end
    checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin errors++; $display("FAIL reset_scyc: got cyc=%b stb=%b want 0", s_cyc_o, s_stb_o); end
    checks++; if (m_ack_o !== 3'b000 || m_err_o !== 3'b000) begin errors++; $display("FAIL reset_resp: got ack=%b err=%b want 000", m_ack_o, m_err_o); end
    checks++; if (s_adr_o !== 36'h0 || s_dat_o !== 32'h0 || m_dat_o !== 32'h0) begin errors++; $display("FAIL reset_data: got adr=%h dat=%h mdat=%h want 0", s_adr_o, s_dat_o, m_dat_o); end
    drive_edge();
    clear_inputs();
    nrst = 1'b1;
  endtask

  task automatic test_single();
    drive_edge();
    set_master(0, 1'b1, 1'b1, 36'h0_1000_0000, 32'hDEADBEEF);
    sample();
    checks++; if (gnt_o !== 3'b000 || s_cyc_o !== 1'b0) begin errors++; $display("FAIL single_latency: got gnt=%b cyc=%b want 000/0", gnt_o, s_cyc_o); end
    drive_edge(); sample();
    checks++; if (gnt_o !== 3'b001) begin errors++; $display("FAIL single_gnt: got %b want 001", gnt_o); end
    checks++; if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_we_o !== 1'b1) begin errors++; $display("FAIL single_ctl: got cyc=%b stb=%b we=%b want 111", s_cyc_o, s_stb_o, s_we_o); end
    checks++; if (s_adr_o !== 36'h0_1000_0000 || s_dat_o !== 32'hDEADBEEF || s_sel_o !== 4'hF) begin errors++; $display("FAIL single_data: got adr=%h dat=%h sel=%h", s_adr_o, s_dat_o, s_sel_o); end
    checks++; if (m_ack_o !== 3'b000) begin errors++; $display("FAIL single_noack: got %b want 000", m_ack_o); end
    drive_edge(); sample();
    drive_edge(); s_ack_i = 1'b1; sample();
    checks++; if (m_ack_o !== 3'b001) begin errors++; $display("FAIL single_ack: got %b want 001", m_ack_o); end
    drive_edge(); s_ack_i = 1'b0; set_master(0, 1'b0, 1'b0, 36'h0, 32'h0); sample();
    checks++; if (s_cyc_o !== 1'b0 || m_ack_o !== 3'b000) begin errors++; $display("FAIL single_drop: got cyc=%b ack=%b want 0/000", s_cyc_o, m_ack_o); end
    drive_edge(); sample();
    checks++; if (gnt_o !== 3'b000) begin errors++; $display("FAIL single_idle: got %b want 000", gnt_o); end
  endtask

  task automatic test_simultaneous();
    int exp_seq [4] = '{0, 1, 2, 0};
    logic [2:0] oh;
    do_reset();
    m_cyc = 3'b111; m_stb = 3'b111;
    for (int g = 0; g < 4; g++) begin
      oh = 3'b001 << exp_seq[g];
      drive_edge(); sample();
      checks++; if (gnt_o !== oh) begin errors++; $display("FAIL simul_gnt%0d: got %b want %b", g, gnt_o, oh); end
      drive_edge(); s_ack_i = 1'b1; sample();
      checks++; if (m_ack_o !== oh) begin errors++; $display("FAIL simul_ack%0d: got %b want %b", g, m_ack_o, oh); end
      drive_edge(); s_ack_i = 1'b0; m_cyc[exp_seq[g]] = 1'b0; m_stb[exp_seq[g]] = 1'b0; sample();
      checks++; if (gnt_o !== oh) begin errors++; $display("FAIL simul_hold%0d: got %b want %b", g, gnt_o, oh); end
      drive_edge();
      if (g < 3) begin
        m_cyc[exp_seq[g]] = 1'b1; m_stb[exp_seq[g]] = 1'b1;
      end else begin
        m_cyc = 3'b000; m_stb = 3'b000;
      end
      sample();
      checks++; if (gnt_o !== 3'b000) begin errors++; $display("FAIL simul_dead%0d: got %b want 000", g, gnt_o); end
    end
  endtask

  task automatic test_block();
    drive_edge();
    set_master(1, 1'b1, 1'b1, 36'h0_2000_0040, 32'h1111_0000);
    set_master(2, 1'b1, 1'b0, 36'h0_3000_0000, 32'h0);
    sample();
    drive_edge(); sample();
    checks++; if (gnt_o !== 3'b010 || s_adr_o !== 36'h0_2000_0040) begin errors++; $display("FAIL block_gnt: got gnt=%b adr=%h want 010", gnt_o, s_adr_o); end
    for (int b = 0; b < 4; b++) begin
      drive_edge(); s_ack_i = 1'b1; sample();
      checks++; if (gnt_o !== 3'b010 || m_ack_o !== 3'b010) begin errors++; $display("FAIL block_beat%0d: got gnt=%b ack=%b want 010/010", b, gnt_o, m_ack_o); end
      drive_edge(); s_ack_i = 1'b0;
      if (b == 3) begin
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
      end else begin
        m_adr[36 +: 36] = m_adr[36 +: 36] + 36'h4;
      end
      sample();
      checks++; if (gnt_o !== 3'b010) begin errors++; $display("FAIL block_hold%0d: got %b want 010", b, gnt_o); end
    end
    drive_edge(); sample();
    checks++; if (gnt_o !== 3'b000) begin errors++; $display("FAIL block_dead: got %b want 000", gnt_o); end
    drive_edge(); sample();
    checks++; if (gnt_o !== 3'b100) begin errors++; $display("FAIL block_next: got %b want 100", gnt_o); end
    drive_edge(); m_cyc[2] = 1'b0; m_stb[2] = 1'b0; sample();
    drive_edge(); sample();
  endtask

  task automatic test_read_broadcast();
    drive_edge();
    set_master(2, 1'b1, 1'b0, 36'h0_4000_0010, 32'h0);
    sample();
    checks++; if (m_ack_o[1:0] !== 2'b00) begin errors++; $display("FAIL read_low0: got %b want 00", m_ack_o[1:0]); end
    drive_edge(); sample();
    checks++; if (gnt_o !== 3'b100 || s_we_o !== 1'b0 || s_adr_o !== 36'h0_4000_0010) begin errors++; $display("FAIL read_gnt: got gnt=%b we=%b adr=%h", gnt_o, s_we_o, s_adr_o); end
    drive_edge(); s_dat_i = 32'h12345678; s_ack_i = 1'b1; sample();
    checks++; if (m_dat_o !== 32'h12345678) begin errors++; $display("FAIL read_data: got %h want 12345678", m_dat_o); end
    checks++; if (m_ack_o !== 3'b100) begin errors++; $display("FAIL read_ack: got %b want 100", m_ack_o); end
    drive_edge(); s_ack_i = 1'b0; s_dat_i = 32'h0; set_master(2, 1'b0, 1'b0, 36'h0, 32'h0); sample();
    checks++; if (m_ack_o !== 3'b000) begin errors++; $display("FAIL read_low1: got %b want 000", m_ack_o); end
    drive_edge(); sample();
  endtask

  task automatic test_reset_mid();
    // move ptr to 2 by granting and releasing master 1
    drive_edge(); set_master(1, 1'b1, 1'b0, 36'h0_0000_0100, 32'h0); sample();
    drive_edge(); sample();
    checks++; if (gnt_o !== 3'b010) begin errors++; $display("FAIL rstmid_pre: got %b want 010", gnt_o); end
    drive_edge(); set_master(1, 1'b0, 1'b0, 36'h0, 32'h0); sample();
    drive_edge(); sample();
    drive_edge(); set_master(0, 1'b1, 1'b0, 36'h0_5000_0000, 32'h0); sample();
    drive_edge(); sample();
    checks++; if (gnt_o !== 3'b001 || s_cyc_o !== 1'b1) begin errors++; $display("FAIL rstmid_gnt: got gnt=%b cyc=%b want 001/1", gnt_o, s_cyc_o); end
    drive_edge(); sample();
    #2;
    nrst = 1'b0; s_ack_i = 1'b1;
    #1;
    checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin errors++; $display("FAIL rstmid_cyc: got cyc=%b stb=%b want 0", s_cyc_o, s_stb_o); end
    checks++; if (gnt_o !== 3'b000 || m_ack_o !== 3'b000) begin errors++; $display("FAIL rstmid_gntack: got gnt=%b ack=%b want 000", gnt_o, m_ack_o); end
    drive_edge(); sample();
    checks++; if (m_ack_o !== 3'b000) begin errors++; $display("FAIL rstmid_noack: got %b want 000", m_ack_o); end
    drive_edge(); nrst = 1'b1; s_ack_i = 1'b0; m_cyc = 3'b111; m_stb = 3'b111; sample();
    checks++; if (gnt_o !== 3'b000) begin errors++; $display("FAIL rstmid_idle: got %b want 000", gnt_o); end
    drive_edge(); sample();
    checks++; if (gnt_o !== 3'b001) begin errors++; $display("FAIL rstmid_ptr: got %b want 001", gnt_o); end
    drive_edge(); clear_inputs(); sample();
    drive_edge(); sample();
  endtask

`ifdef WB_ARBITER_WATCHDOG_EN
  task automatic test_watchdog();
    do_reset();
    set_master(0, 1'b1, 1'b1, 36'h0_6000_0000, 32'hCAFE0000);
    set_master(1, 1'b1, 1'b0, 36'h0_7000_0000, 32'h0);
    sample();
    drive_edge(); sample();
    for (int k = 0; k < 8; k++) begin
      checks++; if (s_cyc_o !== 1'b1 || gnt_o !== 3'b001 || m_err_o !== 3'b000) begin errors++; $display("FAIL wd_stall%0d: got cyc=%b gnt=%b err=%b", k, s_cyc_o, gnt_o, m_err_o); end
      drive_edge(); sample();
    end
    checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin errors++; $display("FAIL wd_abort_cyc: got cyc=%b stb=%b want 0", s_cyc_o, s_stb_o); end
    checks++; if (m_err_o !== 3'b001) begin errors++; $display("FAIL wd_err: got %b want 001", m_err_o); end
    drive_edge(); sample();
    checks++; if (m_err_o !== 3'b000 || gnt_o !== 3'b000) begin errors++; $display("FAIL wd_idle: got err=%b gnt=%b want 000", m_err_o, gnt_o); end
    drive_edge(); sample();
    checks++; if (gnt_o !== 3'b010) begin errors++; $display("FAIL wd_next: got %b want 010", gnt_o); end
    drive_edge(); clear_inputs(); sample();
    drive_edge(); sample();
  endtask
`endif

  initial begin
    nrst = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_simultaneous();
    test_block();
    test_read_broadcast();
    test_reset_mid();
`ifdef WB_ARBITER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin Wishbone bus arbiter that shares the single northbridge Wishbone slave port between up to four masters, e.g. the LIMB bridge, the CPU port and DMA. It sits between the master-side glue blocks and the address decoder. It holds a grant for the whole `cyc` of a master, which keeps multi-beat block transfers atomic. An optional watchdog terminates stalled cycles with an error.

## Interface
Parameters:
- `NM`, 3: number of masters, 2..4.
- `TIMEOUT`, 1023: watchdog limit in clocks, 1..65535. Used only with the watchdog compiled in.

Ports:
- `clk` in 1: Wishbone clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `m_cyc_i` in NM: per-master `cyc`.
- `m_stb_i` in NM: per-master `stb`.
- `m_we_i` in NM: per-master `we`.
- `m_sel_i` in 4·NM: byte selects, master i at [4i+:4].
- `m_adr_i` in 36·NM: addresses, master i at [36i+:36].
- `m_dat_i` in 32·NM: write data, master i at [32i+:32].
- `m_dat_o` out 32: slave read data, broadcast to all masters.
- `m_ack_o` out NM: per-master `ack`.
- `m_err_o` out NM: per-master `err`.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1: slave-side control.
- `s_sel_o` out 4, `s_adr_o` out 36, `s_dat_o` out 32: slave-side selects, address and write data.
- `s_dat_i` in 32, `s_ack_i` in 1, `s_err_i` in 1: slave responses.
- `gnt_o` out NM: one-hot current grant, all zero when idle.

## Operation
- State machine with states IDLE, OWNED and (watchdog builds only) ABORT.
- **IDLE**
  - `gnt_o` = 0; all slave outputs are 0.
  - If any `m_cyc_i` bit is high, register a grant to the first requester found searching upward from pointer `ptr`, wrapping modulo NM. Go to OWNED.
- **OWNED**
  - Slave outputs are the granted master's signals.
  - `s_ack_i` and `s_err_i` are routed only to the granted bit of `m_ack_o` / `m_err_o`; other bits are 0.
  - When the granted `m_cyc_i` goes low: `s_cyc_o` and `s_stb_o` drop combinationally, `ptr` becomes granted index + 1 mod NM, and the next state is IDLE.
- **Request ordering**
  - Requests from other masters during OWNED are ignored until the grant is released.
  - Simultaneous requests are resolved by `ptr` only.
- **Fairness**: the pointer rotates after every release, so no master is granted twice while another master's `cyc` stays continuously high.
- **Gating**: all slave-side outputs are ANDed with the grant register, so there are no glitches from non-granted masters.
- **Drive rule**: `s_stb_o` is never high without `s_cyc_o`.
- **Reset**
  - Reset values: all outputs 0, `ptr` = 0, state IDLE.
  - Reset asserted mid-cycle drops `s_cyc_o` immediately (asynchronously). No ack or err is delivered to the master.

## Timing
- **Grant latency**: `m_cyc_i` high before edge N gives `gnt_o` and `s_cyc_o` high in the cycle after edge N, one clock of arbitration.
- **Turnaround**: there is one dead IDLE cycle between successive grants. Back-to-back owners see `s_cyc_o` low for exactly one clock.
- **Data path**: ack, err and read data pass combinationally, with zero added latency once granted.
- **Watchdog timing**: counter clears on any `s_ack_i`/`s_err_i` or when `s_stb_o` is low. When it reaches TIMEOUT, the state goes to ABORT for one clock.

## Configuration
- Macro `WB_ARBITER_WATCHDOG_EN`.
- **Defined**: 16-bit stall counter and ABORT state are compiled in. In ABORT:
  - `s_cyc_o` and `s_stb_o` are forced 0.
  - The granted master's `m_err_o` pulses for one clock.
  - The grant is then released as on a `cyc` drop: `ptr` advances and the state goes to IDLE.
- **Undefined**: no counter and no ABORT state. `m_err_o` carries only `s_err_i`, and a stalled slave holds the bus indefinitely.

## Structure
- Package `wb_arbiter_pkg`:
  - width constants `WB_ADR_W` = 36, `WB_DAT_W` = 32, `WB_SEL_W` = 4;
  - state encoding localparams IDLE/OWNED/ABORT (one-hot);
  - `MAX_NM` = 4.
- Sub-module `rr_pick`: combinational round-robin priority encoder with inputs `req[NM]` and `ptr` and a one-hot `gnt[NM]` output. It is reused by the future interrupt controller.

## Test plan
- **Single request**: reset, then master 0 raises `cyc`/`stb` with write to `adr` 0x0_1000_0000, `dat` 0xDEADBEEF; slave acks after 3 clocks.
  - `gnt_o` = 001 one clock after the request.
  - `s_adr_o`/`s_dat_o` match; `m_ack_o` = 001 for one clock; IDLE follows the `cyc` drop.
- **Simultaneous requests**: all three masters request continuously, each doing one beat per grant.
  - Grants go in order 0, 1, 2, 0, with exactly one dead cycle between grants.
- **Block atomicity**: master 1 holds `cyc` for 4 beats while master 2 requests.
  - `gnt_o` stays 010 through all 4 acks; master 2 is granted only after the release.
- **Read broadcast**: master 2 reads and the slave returns 0x12345678.
  - `m_dat_o` = 0x12345678; `m_ack_o` = 100; bits 0 and 1 of `m_ack_o` stay 0 throughout.
- **Reset mid-cycle**: `nrst` low while master 0 is granted and the slave is stalled.
  - `s_cyc_o`, `gnt_o` and `m_ack_o` go 0 immediately; `ptr` is 0 after release.
- **Watchdog** (`WB_ARBITER_WATCHDOG_EN`, TIMEOUT = 8): slave never acks.
  - After exactly 8 stalled clocks `s_cyc_o` goes 0 and `m_err_o[0]` pulses one clock.
  - The next pending master is then granted.
